// File: rtl/qbus_pkg.sv
// qbus_pkg: shared types and constants for the Qbus DMA master.
//   state_t     - bus-master sequencer states
//   cmd_t       - registered command payload (write flag, address, write data)
//   DEF_*       - default bus timing in clocks
//   IOPAGE_MASK - I/O page decode (top 8 KB of the 22-bit space)
package qbus_pkg;

   localparam int unsigned ADDR_W = 22;
   localparam int unsigned DATA_W = 16;

   localparam int unsigned DEF_T_ASET = 8;
   localparam int unsigned DEF_T_AHLD = 6;
   localparam int unsigned DEF_T_DSET = 8;
   localparam int unsigned DEF_T_DSKW = 4;
   localparam int unsigned DEF_TMO    = 1000;

   localparam logic [ADDR_W-1:0] IOPAGE_MASK = 22'o17760000;

   typedef enum logic [3:0] {
      ST_IDLE, ST_REQ, ST_GRANT, ST_ADDR, ST_SYNC,
      ST_DATA, ST_RPLY, ST_TERM, ST_REL
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   // True when the address falls in the I/O page (drives BBS7).
   function automatic logic is_iopage(input logic [ADDR_W-1:0] a);
      return (a & IOPAGE_MASK) == IOPAGE_MASK;
   endfunction

endpackage

// File: rtl/qbus_sync.sv
// qbus_sync: two-flop synchronizer for active-low bus lines.
//   clock, reset - system clock, async active-high reset
//   d            - asynchronous input vector
//   q            - synchronized output; resets to the negated level (all ones)
module qbus_sync #(
   parameter int unsigned W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/qbus_dma_master.sv
// qbus_dma_master: single-word DMA bus master for the Qbus.
//   clock, reset        - system clock, async active-high reset
//   cmd_*               - command handshake (accepted only in IDLE)
//   rsp_*               - one-clock completion pulse with read data / error
//   BDALf_IN            - inverted-sense BDAL receivers
//   BDALf_OUT/OE, Outbound - true-sense BDAL drive and enables
//   BSYNCf..BINITf      - active-low bus inputs (synchronized internally)
//   BDMRg..BDMGOg       - active-high gate drives
// Build option: define QBUS_DMA_TIMEOUT_EN to enable the reply timeout
// (non-existent memory reported through rsp_err).
module qbus_dma_master
   import qbus_pkg::*;
#(
   parameter int unsigned T_ASET = DEF_T_ASET,
   parameter int unsigned T_AHLD = DEF_T_AHLD,
   parameter int unsigned T_DSET = DEF_T_DSET,
   parameter int unsigned T_DSKW = DEF_T_DSKW,
   parameter int unsigned TMO    = DEF_TMO
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic [ADDR_W-1:0] BDALf_IN,
   output logic [ADDR_W-1:0] BDALf_OUT,
   output logic [ADDR_W-1:0] BDALf_OE,
   output logic              Outbound,
   input  logic              BSYNCf,
   input  logic              BRPLYf,
   input  logic              BDMGIf,
   input  logic              BINITf,
   output logic              BDMRg,
   output logic              BSACKg,
   output logic              BSYNCg,
   output logic              BDINg,
   output logic              BDOUTg,
   output logic              BWTBTg,
   output logic              BBS7g,
   output logic              BDMGOg
);

   localparam int unsigned SYNC_W = DATA_W + 4;
   localparam int unsigned CNT_W  = $clog2(T_ASET + T_AHLD + T_DSET + T_DSKW + TMO + 1);

   logic [SYNC_W-1:0] sync_q;
   logic              bsync_h, rply_h, dmgi_h, init_h;
   logic [DATA_W-1:0] bdal_s;
   logic              unused_bits;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   cmd_t              cmd_q, cmd_d;
   logic              seen_q, seen_d;
   logic [DATA_W-1:0] rdata_d;
   logic              addr_phase, wdata_phase;

   logic              cmd_ready_d, rsp_valid_d, outbound_d;
   logic [ADDR_W-1:0] dal_out_d, dal_oe_d;
   logic              dmr_d, sack_d, bsync_d, din_d, dout_d, wtbt_d, bbs7_d, dmgo_d;

   // Bus inputs, including read data, cross into the clock domain here.
   qbus_sync #(.W(SYNC_W)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     ({BDALf_IN[DATA_W-1:0], BINITf, BDMGIf, BRPLYf, BSYNCf}),
      .q     (sync_q)
   );

   assign bsync_h = sync_q[0];
   assign rply_h  = sync_q[1];
   assign dmgi_h  = sync_q[2];
   assign init_h  = sync_q[3];
   assign bdal_s  = sync_q[SYNC_W-1:4];

   // Address bit 0 is forced low; BDAL<21:16> carry no read data.
   assign unused_bits = ^{cmd_addr[0], BDALf_IN[ADDR_W-1:DATA_W]};

`ifdef QBUS_DMA_TIMEOUT_EN
   logic err_q, err_d, rsp_err_d;
`endif

   // Next state, counters and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      seen_d  = seen_q;
      rdata_d = rsp_rdata;
`ifdef QBUS_DMA_TIMEOUT_EN
      err_d   = err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready && init_h) begin
               cmd_d.write = cmd_write;
               cmd_d.addr  = {cmd_addr[ADDR_W-1:1], 1'b0};
               cmd_d.wdata = cmd_wdata;
               state_d     = ST_REQ;
`ifdef QBUS_DMA_TIMEOUT_EN
               err_d       = 1'b0;
`endif
            end
         end
         ST_REQ: begin
            if (!dmgi_h) state_d = ST_GRANT;
         end
         ST_GRANT: begin
            // Previous master must have fully released SYNC and RPLY.
            if (bsync_h && rply_h) begin
               state_d = ST_ADDR;
               cnt_d   = '0;
            end
         end
         ST_ADDR: begin
            if (cnt_q == CNT_W'(T_ASET - 1)) begin
               state_d = ST_SYNC;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         ST_SYNC: begin
            if (cnt_q == CNT_W'(T_AHLD - 1)) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         ST_DATA: begin
            // Reads move on at once; writes hold data for the setup time.
            if (!cmd_q.write || cnt_q == CNT_W'(T_DSET - 1)) begin
               state_d = ST_RPLY;
               cnt_d   = '0;
               seen_d  = 1'b0;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         ST_RPLY: begin
            if (seen_q) begin
               if (cnt_q == CNT_W'(T_DSKW - 1)) begin
                  state_d = ST_TERM;
                  cnt_d   = '0;
                  if (!cmd_q.write) rdata_d = ~bdal_s;
               end else cnt_d = cnt_q + CNT_W'(1);
            end else if (!rply_h) begin
               seen_d = 1'b1;
               cnt_d  = '0;
            end
`ifdef QBUS_DMA_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TMO - 1)) begin
               state_d = ST_REL;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
`endif
         end
         ST_TERM: begin
            if (rply_h) state_d = ST_REL;
         end
         ST_REL:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Bus init overrides everything and drops the transfer silently.
      if (!init_h) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         seen_d  = 1'b0;
         rdata_d = rsp_rdata;
      end

      addr_phase  = (state_d == ST_ADDR) || (state_d == ST_SYNC);
      wdata_phase = cmd_d.write && (state_d inside {ST_DATA, ST_RPLY, ST_TERM});

      cmd_ready_d = (state_d == ST_IDLE) && init_h;
      dmgo_d      = (state_d == ST_IDLE) && !dmgi_h;
      dmr_d       = (state_d == ST_REQ);
      sack_d      = state_d inside {ST_GRANT, ST_ADDR, ST_SYNC, ST_DATA, ST_RPLY, ST_TERM};
      bsync_d     = state_d inside {ST_SYNC, ST_DATA, ST_RPLY, ST_TERM};
      din_d       = !cmd_d.write && (state_d inside {ST_DATA, ST_RPLY});
      dout_d      = cmd_d.write && (state_d == ST_RPLY);
      wtbt_d      = addr_phase && cmd_d.write;
      bbs7_d      = addr_phase && is_iopage(cmd_d.addr);
      rsp_valid_d = (state_d == ST_REL);

      dal_out_d = '0;
      dal_oe_d  = '0;
      if (addr_phase) begin
         dal_out_d = cmd_d.addr;
         dal_oe_d  = '1;
      end else if (wdata_phase) begin
         dal_out_d = {{(ADDR_W - DATA_W){1'b0}}, cmd_d.wdata};
         dal_oe_d  = '1;
      end
      outbound_d = |dal_oe_d;

`ifdef QBUS_DMA_TIMEOUT_EN
      rsp_err_d = rsp_valid_d && err_d;
`endif
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         cmd_q     <= '0;
         seen_q    <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         BDALf_OUT <= '0;
         BDALf_OE  <= '0;
         Outbound  <= 1'b0;
         BDMRg     <= 1'b0;
         BSACKg    <= 1'b0;
         BSYNCg    <= 1'b0;
         BDINg     <= 1'b0;
         BDOUTg    <= 1'b0;
         BWTBTg    <= 1'b0;
         BBS7g     <= 1'b0;
         BDMGOg    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         seen_q    <= seen_d;
         cmd_ready <= cmd_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rdata_d;
         BDALf_OUT <= dal_out_d;
         BDALf_OE  <= dal_oe_d;
         Outbound  <= outbound_d;
         BDMRg     <= dmr_d;
         BSACKg    <= sack_d;
         BSYNCg    <= bsync_d;
         BDINg     <= din_d;
         BDOUTg    <= dout_d;
         BWTBTg    <= wtbt_d;
         BBS7g     <= bbs7_d;
         BDMGOg    <= dmgo_d;
      end
   end

`ifdef QBUS_DMA_TIMEOUT_EN
   // Non-existent-memory flag and its report.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q   <= 1'b0;
         rsp_err <= 1'b0;
      end else begin
         err_q   <= err_d;
         rsp_err <= rsp_err_d;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_qbus_dma_master.sv
// tb_qbus_dma_master: directed bench for qbus_dma_master with a simple
// Qbus slave/arbiter model driven from the main sequence.
module tb_qbus_dma_master;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [21:0] cmd_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic [21:0] BDALf_IN = '1, BDALf_OUT, BDALf_OE;
   logic        Outbound;
   logic        BSYNCf = 1'b1, BRPLYf = 1'b1, BDMGIf = 1'b1, BINITf = 1'b1;
   logic        BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMGOg;

   int n_checks = 0;
   int n_pass   = 0;

   // Monitor counters (written only by the monitor).
   int n_dindout = 0, n_syncdmr = 0, n_outb = 0, n_rsp = 0, n_rsp_long = 0;
   int n_bs7 = 0, n_bs7_addr = 0, n_wtbt = 0, n_wtbt_bad = 0, n_dmgo_busy = 0;
   int dcnt = 0, dout_setup = 0;
   logic dout_prev = 1'b0, rsp_prev = 1'b0;
   logic [21:0] exp_addr = '0, exp_word = '0;

   localparam int P_DMR = 0, P_SACK = 1, P_SYNC = 2, P_XFER = 3, P_RSP = 4, P_OE = 5, P_RDY = 6;

   qbus_dma_master #(
      .T_ASET(8), .T_AHLD(6), .T_DSET(8), .T_DSKW(4), .TMO(50)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .BDALf_IN(BDALf_IN), .BDALf_OUT(BDALf_OUT), .BDALf_OE(BDALf_OE), .Outbound(Outbound),
      .BSYNCf(BSYNCf), .BRPLYf(BRPLYf), .BDMGIf(BDMGIf), .BINITf(BINITf),
      .BDMRg(BDMRg), .BSACKg(BSACKg), .BSYNCg(BSYNCg), .BDINg(BDINg), .BDOUTg(BDOUTg),
      .BWTBTg(BWTBTg), .BBS7g(BBS7g), .BDMGOg(BDMGOg)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [10:0] gates();
      return {BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMGOg, Outbound, rsp_valid, rsp_err};
   endfunction

   function automatic logic probe(input int id);
      case (id)
         P_DMR:   return BDMRg;
         P_SACK:  return BSACKg;
         P_SYNC:  return BSYNCg;
         P_XFER:  return BDINg | BDOUTg;
         P_RSP:   return rsp_valid;
         P_OE:    return |BDALf_OE;
         P_RDY:   return cmd_ready;
         default: return 1'bx;
      endcase
   endfunction

   // Bounded wait on a DUT signal; an expired budget shows up as a failed check.
   task automatic wait_for(input string tag, input int id, input logic lvl, input int budget, output int n);
      n = 0;
      while (probe(id) !== lvl && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(probe(id)), 32'(lvl));
   endtask

   // Bus-protocol monitor sampled on the falling edge.
   always @(negedge clock) begin
      if (!reset) begin
         if (BDINg && BDOUTg) n_dindout++;
         if (BSYNCg && BDMRg) n_syncdmr++;
         if (Outbound != |BDALf_OE) n_outb++;
         if (rsp_valid) n_rsp++;
         if (rsp_valid && rsp_prev) n_rsp_long++;
         if (BBS7g) n_bs7++;
         if (BBS7g && !BSYNCg && BDALf_OE == '1) n_bs7_addr++;
         if (BWTBTg) n_wtbt++;
         if (BWTBTg && (BDINg || BDOUTg || BDALf_OUT != exp_addr)) n_wtbt_bad++;
         if (BDMGOg && (BDMRg || BSACKg)) n_dmgo_busy++;
         if (BDOUTg && !dout_prev) dout_setup = dcnt;
         if (BDALf_OE != '0 && BDALf_OUT == exp_word) dcnt++;
         else dcnt = 0;
      end
      dout_prev = BDOUTg;
      rsp_prev  = rsp_valid;
   end

   task automatic send_cmd(input logic wr, input logic [21:0] addr, input logic [15:0] data);
      int n;
      wait_for("cmd_ready", P_RDY, 1'b1, 10, n);
      cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      check("cmd_taken", 32'(cmd_ready), 0);
   endtask

   // Arbiter side: answer the request, release the grant once SACK is seen.
   task automatic grant_bus(input bit busy);
      int n;
      wait_for("dmr", P_DMR, 1'b1, 20, n);
      if (busy) BRPLYf = 1'b0;
      BDMGIf = 1'b0;
      wait_for("sack", P_SACK, 1'b1, 10, n);
      check("dmgo_blocked", 32'(BDMGOg), 0);
      check("dmr_neg", 32'(BDMRg), 0);
      BDMGIf = 1'b1;
      if (busy) begin
         repeat (20) @(negedge clock);
         check("busy_sync_held", 32'(BSYNCg), 0);
         check("busy_oe_held", 32'(BDALf_OE), 0);
         BRPLYf = 1'b1;
      end
   endtask

   // Full slave transaction; word is the read reply or the expected write data.
   task automatic bus_cycle(input logic wr, input logic [15:0] word, input bit busy);
      int n;
      grant_bus(busy);
      wait_for("sync", P_SYNC, 1'b1, 40, n);
      wait_for("xfer", P_XFER, 1'b1, 40, n);
      check("dir", {30'd0, BDINg, BDOUTg}, wr ? 32'd1 : 32'd2);
      if (wr) check("wr_bus_data", 32'(BDALf_OUT), 32'(word));
      else    check("rd_bus_off", {29'd0, Outbound, |BDALf_OE, BWTBTg}, 0);
      if (!wr) BDALf_IN = ~{6'd0, word};
      BRPLYf = 1'b0;
      wait_for("xfer_off", P_XFER, 1'b0, 20, n);
      BRPLYf = 1'b1;
      BDALf_IN = '1;
      wait_for("rsp", P_RSP, 1'b1, 20, n);
   endtask

   initial begin
      int n, b_rsp, b_bs7, b_bs7a, b_wtbt, b_wbad;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Reset state
      check("rst_ready", 32'(cmd_ready), 1);
      check("rst_gates", 32'(gates()), 0);
      check("rst_oe", 32'(BDALf_OE), 0);
      check("rst_out", 32'(BDALf_OUT), 0);
      check("rst_rdata", 32'(rsp_rdata), 0);

      // Read from ordinary memory
      b_rsp = n_rsp; b_bs7 = n_bs7; b_wtbt = n_wtbt;
      exp_addr = 22'o00001000;
      send_cmd(1'b0, 22'o00001000, 16'h0);
      bus_cycle(1'b0, 16'o123456, 1'b0);
      check("rd_data", 32'(rsp_rdata), 32'(16'o123456));
      check("rd_err", 32'(rsp_err), 0);
      @(negedge clock);
      check("rd_pulse", 32'(rsp_valid), 0);
      check("rd_bs7", 32'(n_bs7 - b_bs7), 0);
      check("rd_wtbt", 32'(n_wtbt - b_wtbt), 0);
      check("rd_rsp_cnt", 32'(n_rsp - b_rsp), 1);

      // Write to the I/O page
      b_bs7a = n_bs7_addr; b_wtbt = n_wtbt; b_wbad = n_wtbt_bad;
      exp_addr = 22'o17772150;
      exp_word = 22'h0000A5;
      send_cmd(1'b1, 22'o17772150, 16'h00A5);
      bus_cycle(1'b1, 16'h00A5, 1'b0);
      check("wr_err", 32'(rsp_err), 0);
      check("wr_bs7_addr", 32'(n_bs7_addr - b_bs7a != 0), 1);
      check("wr_wtbt_seen", 32'(n_wtbt - b_wtbt != 0), 1);
      check("wr_wtbt_bad", 32'(n_wtbt_bad - b_wbad), 0);
      check("wr_dout_setup", 32'(dout_setup >= 8), 1);
      check("rdata_hold", 32'(rsp_rdata), 32'(16'o123456));
      @(negedge clock);

      // Grant passes through when idle
      BDMGIf = 1'b0;
      repeat (3) @(negedge clock);
      check("gnt_pass", 32'(BDMGOg), 1);
      BDMGIf = 1'b1;
      repeat (3) @(negedge clock);
      check("gnt_drop", 32'(BDMGOg), 0);

      // Pending command takes the grant; bus still busy with RPLY low
      exp_addr = 22'o00002000;
      send_cmd(1'b0, 22'o00002000, 16'h0);
      bus_cycle(1'b0, 16'h5A3C, 1'b1);
      check("busy_rd_data", 32'(rsp_rdata), 32'h5A3C);
      @(negedge clock);

      // No reply
      exp_addr = 22'o00003000;
      b_rsp = n_rsp;
      send_cmd(1'b0, 22'o00003000, 16'h0);
      grant_bus(1'b0);
      wait_for("nxm_din", P_XFER, 1'b1, 60, n);
`ifdef QBUS_DMA_TIMEOUT_EN
      wait_for("tmo_rsp", P_RSP, 1'b1, 100, n);
      check("tmo_err", 32'(rsp_err), 1);
      check("tmo_latency", 32'(n >= 48 && n <= 52), 1);
      check("tmo_drives", {26'd0, BSYNCg, BDINg, BDOUTg, BSACKg, Outbound, |BDALf_OE}, 0);
      @(negedge clock);
      check("tmo_rdata_hold", 32'(rsp_rdata), 32'h5A3C);
      send_cmd(1'b0, 22'o00003000, 16'h0);
      grant_bus(1'b0);
      wait_for("abort_din", P_XFER, 1'b1, 60, n);
      repeat (10) @(negedge clock);
`else
      repeat (100) @(negedge clock);
      check("stuck_din", 32'(BDINg), 1);
      check("stuck_sync", 32'(BSYNCg), 1);
      check("stuck_no_rsp", 32'(n_rsp - b_rsp), 0);
`endif

      // Bus init aborts an outstanding read
      b_rsp = n_rsp;
      BINITf = 1'b0;
      repeat (4) @(negedge clock);
      check("abort_gates", 32'(gates()), 0);
      check("abort_oe", 32'(BDALf_OE), 0);
      check("abort_ready", 32'(cmd_ready), 0);
      check("abort_no_rsp", 32'(n_rsp - b_rsp), 0);
      BINITf = 1'b1;
      repeat (4) @(negedge clock);
      check("abort_ready_back", 32'(cmd_ready), 1);

      // Asynchronous reset in the middle of a write address phase
      exp_addr = 22'o17772150;
      exp_word = 22'h001234;
      send_cmd(1'b1, 22'o17772150, 16'h1234);
      grant_bus(1'b0);
      wait_for("mid_oe", P_OE, 1'b1, 20, n);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_gates", 32'(gates()), 0);
      check("mid_rst_oe", 32'(BDALf_OE), 0);
      check("mid_rst_out", 32'(BDALf_OUT), 0);
      check("mid_rst_ready", 32'(cmd_ready), 1);
      check("mid_rst_rdata", 32'(rsp_rdata), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Protocol invariants over the whole run
      check("inv_din_dout", 32'(n_dindout), 0);
      check("inv_sync_dmr", 32'(n_syncdmr), 0);
      check("inv_outbound", 32'(n_outb), 0);
      check("inv_rsp_width", 32'(n_rsp_long), 0);
      check("inv_dmgo_busy", 32'(n_dmgo_busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/qbus_dma_master.md
QBUS_DMA_MASTER -- requirements
Module: qbus_dma_master

Interface
REQ-001 SHALL have parameters: T_ASET, default 8, address-to-BSYNC setup in clocks; T_AHLD, default 6, address hold after BSYNC; T_DSET, default 8, write-data setup before BDOUT; T_DSKW, default 4, BRPLY-to-data-sample deskew; TMO, default 1000, reply timeout in clocks.
REQ-002 SHALL have ports, clock and reset first: clock in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-003 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1; cmd_addr in 22, byte address, bit0 ignored; cmd_wdata in 16.
REQ-004 SHALL have response ports: rsp_valid out 1, one-clock pulse; rsp_rdata out 16; rsp_err out 1.
REQ-005 SHALL have Qbus ports: BDALf_IN in 22, inverted bus sense; BDALf_OUT out 22, true-sense data; BDALf_OE out 22; Outbound out 1; BSYNCf, BRPLYf, BDMGIf, BINITf in 1, active-low sense; BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMGOg out 1, active-high gate drives.

Function
REQ-006 SHALL pass every active-low input through a two-flop synchronizer; all timing below counts from synchronized edges.
REQ-007 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready high only in IDLE; command fields registered on acceptance.
REQ-008 SHALL step through states IDLE, REQ, GRANT, ADDR, SYNC, DATA, RPLY, TERM, REL.
REQ-009 REQ: assert BDMRg; on BDMGIf low go to GRANT.
REQ-010 GRANT: assert BSACKg, negate BDMRg; wait until BSYNCf and BRPLYf are both high, then go to ADDR.
REQ-011 ADDR: drive BDALf_OUT = cmd_addr, BDALf_OE all ones, Outbound=1; BBS7g = (cmd_addr[21:13] all ones); BWTBTg = cmd_write; after T_ASET clocks go to SYNC.
REQ-012 SYNC: assert BSYNCg, keep address for T_AHLD clocks, negate BBS7g, then go to DATA.
REQ-013 DATA, read: BDALf_OE=0, Outbound=0, BWTBTg=0, assert BDINg. DATA, write: drive BDALf_OUT[15:0]=cmd_wdata, [21:16]=0; BWTBTg=0 (word); after T_DSET clocks assert BDOUTg. Either way then go to RPLY.
REQ-014 RPLY: on BRPLYf low wait T_DSKW clocks; on read latch rsp_rdata = ~BDALf_IN[15:0]; negate BDINg/BDOUTg; go to TERM.
REQ-015 TERM: on BRPLYf high negate BSYNCg, stop driving BDAL, go to REL.
REQ-016 REL: negate BSACKg; pulse rsp_valid for one clock, rsp_err=0; return to IDLE.
REQ-017 BDMGOg SHALL equal the synchronized grant-in (BDMGIf low) while in IDLE, and SHALL be 0 in all other states (grant not passed while requesting or owning the bus).
REQ-018 SHALL never assert BDINg and BDOUTg together; BSYNCg never asserted while BDMRg is high.
REQ-019 Outbound SHALL be 1 exactly when any BDALf_OE bit is 1.
REQ-020 rsp_rdata SHALL hold its value until the next read completes; it is 0 after reset.

Reset
REQ-021 reset SHALL force IDLE asynchronously; every output 0 except cmd_ready=1; all counters cleared.
REQ-022 Synchronized BINITf low SHALL abort any state to IDLE within one clock, releasing all bus drives with no rsp_valid; cmd_ready stays 0 while BINITf is low.

Configuration
REQ-023 Macro QBUS_DMA_TIMEOUT_EN: when defined, a counter runs in RPLY. If BRPLYf is not seen within TMO clocks, the block negates BDINg/BDOUTg and BSYNCg, releases BDAL and BSACKg, and pulses rsp_valid with rsp_err=1 (non-existent memory). When undefined, RPLY waits indefinitely and rsp_err is tied to 0.

Structure
REQ-024 Package qbus_pkg SHALL hold the state enum, the default timing constants and the I/O-page address mask (22'o17760000).
REQ-025 Sub-module qbus_sync SHALL implement the two-flop synchronizer, parameterized in width, with async active-high reset to the negated level (1).

Verification
REQ-026 Read: cmd read, addr 22'o00001000; bus model grants, replies with data 16'o123456 -> rsp_valid once, rsp_rdata=16'o123456, rsp_err=0, BBS7g never asserted.
REQ-027 Write: addr 22'o17772150, data 16'h00A5 -> BBS7g high during ADDR; bus model sees BDOUTg at least T_DSET clocks after data valid, BWTBTg high only during address phase.
REQ-028 Grant chain: no pending command, BDMGIf low -> BDMGOg follows within 3 clocks; with a command pending, BDMGOg stays 0 and BSACKg asserts.
REQ-029 Bus busy: grant arrives while BRPLYf is still low -> BSYNCg stays 0 until BRPLYf goes high.
REQ-030 Timeout (macro on, TMO=50): no reply -> rsp_err=1 at 50+/-2 clocks after BDINg, all drives 0; macro off -> block stays in RPLY.
REQ-031 Abort: BINITf low during RPLY -> all g outputs and BDALf_OE 0 within 4 clocks, no rsp_valid; reset asserted mid-write -> outputs 0 immediately.
